// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and types for the instruction fetch stage
package if_fetch_pkg;
  localparam logic [31:0] INST_NOP = 32'h0;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int FETCH_DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pair_t;
endpackage

// File: rtl/if_fetch_fifo2.sv
// fetch_fifo2: 2-entry synchronous FIFO with flush, count and combinational head
module fetch_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem0, mem1;
  assign head = mem0;
  always_ff @(posedge clk) begin
    if (!rst || flush) count <= 2'd0;
    else count <= count + 2'(push) - 2'(pop);
    if (pop) mem0 <= (push && count == 2'd1) ? din : mem1;
    else if (push && count == 2'd0) mem0 <= din;
    if (push && count == (pop ? 2'd2 : 2'd1)) mem1 <= din;
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: credit-limited sequential instruction fetch with redirect and response discard
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branchEnable_i,
  input  logic [31:0] branchAddr_i,
  output logic        imemReq_o,
  output logic [31:0] imemAddr_o,
  input  logic        imemGnt_i,
  input  logic        imemRvalid_i,
  input  logic [31:0] imemRdata_i,
  output logic        instValid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);
  logic [31:0] fetch_pc, pcq_head;
  fetch_pair_t outq_head;
  logic [1:0] outstanding, kill_cnt, pcq_cnt, outq_cnt;
  logic pop, grant, rsp, drop;
  assign pop = instValid_o & ~stall_i & ~branchEnable_i;
  assign imemReq_o = rst & ~branchEnable_i &
    ({1'b0, outstanding} + {1'b0, outq_cnt} - {2'b0, pop} < 3'(DEPTH));
  assign imemAddr_o = fetch_pc;
  assign grant = imemReq_o & imemGnt_i;
  assign rsp = rst & imemRvalid_i;
  // a response arriving in the redirect cycle belongs to the old path
  assign drop = (kill_cnt != 2'd0) | branchEnable_i;
  assign instValid_o = rst & (outq_cnt != 2'd0);
  assign {pc_o, inst_o} = instValid_o ? outq_head : {32'h0, INST_NOP};
  always_ff @(posedge clk)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      outstanding <= 2'd0;
      kill_cnt <= 2'd0;
    end else begin
      outstanding <= outstanding + 2'(grant) - 2'(rsp);
      if (branchEnable_i) begin
        fetch_pc <= branchAddr_i & ~32'd3;
        kill_cnt <= outstanding - 2'(rsp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_STEP;
        if (rsp && kill_cnt != 2'd0) kill_cnt <= kill_cnt - 2'd1;
      end
    end
  fetch_fifo2 #(.W(32)) pcq (
    .clk(clk), .rst(rst), .push(grant), .pop(rsp), .flush(1'b0),
    .din(fetch_pc), .head(pcq_head), .count(pcq_cnt)
  );
  fetch_fifo2 #(.W($bits(fetch_pair_t))) outq (
    .clk(clk), .rst(rst), .push(rsp & ~drop), .pop(pop), .flush(branchEnable_i),
    .din({pcq_head, imemRdata_i}), .head(outq_head), .count(outq_cnt)
  );
  assert property (@(posedge clk) rsp |-> pcq_cnt != 2'd0);
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized checks of if_fetch against a queue-based fetch model
module tb_if_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0, rst = 1'b0, stall_i = 1'b0, branchEnable_i = 1'b0;
  logic imemGnt_i = 1'b0, imemRvalid_i = 1'b0;
  logic [31:0] branchAddr_i = 32'h0, imemRdata_i = 32'h0;
  logic imemReq_o, instValid_o;
  logic [31:0] imemAddr_o, inst_o, pc_o;
  int chk = 0, err = 0, cyc = 0;
  typedef struct {logic [31:0] a; int t;} mreq_t;
  typedef struct {logic [31:0] a; bit kill;} pend_t;
  mreq_t memq[$];
  pend_t m_pend[$];
  logic [31:0] m_out[$];
  logic [31:0] m_fetch = 32'h0;
  logic exp_req, exp_valid, obs_req, obs_valid;
  logic [31:0] exp_addr, exp_pc, exp_inst, obs_addr, obs_pc, obs_inst;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branchEnable_i(branchEnable_i),
    .branchAddr_i(branchAddr_i), .imemReq_o(imemReq_o), .imemAddr_o(imemAddr_o),
    .imemGnt_i(imemGnt_i), .imemRvalid_i(imemRvalid_i), .imemRdata_i(imemRdata_i),
    .instValid_o(instValid_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  // one clock: drive inputs, predict, sample, then advance memory and model
  task automatic step(input bit r, input bit st, input bit br, input logic [31:0] ba,
                      input bit g, input bit rv);
    bit pop, mg;
    pend_t p;
    @(negedge clk);
    rst = r; stall_i = st; branchEnable_i = br; branchAddr_i = ba; imemGnt_i = g;
    imemRvalid_i = rv && memq.size() > 0 && memq[0].t < cyc;
    imemRdata_i = imemRvalid_i ? memq[0].a ^ K : $urandom;
    exp_valid = r && m_out.size() > 0;
    exp_pc = exp_valid ? m_out[0] : 32'h0;
    exp_inst = exp_valid ? exp_pc ^ K : 32'h0;
    pop = exp_valid && !st && !br;
    exp_req = r && !br && (m_pend.size() + m_out.size() - int'(pop) < 2);
    exp_addr = m_fetch;
    mg = exp_req && g;
    #1;
    obs_req = imemReq_o; obs_addr = imemAddr_o; obs_valid = instValid_o;
    obs_pc = pc_o; obs_inst = inst_o;
    @(posedge clk);
    if (!r) begin
      memq.delete(); m_pend.delete(); m_out.delete(); m_fetch = 32'h0;
    end else begin
      if (imemRvalid_i) void'(memq.pop_front());
      if (obs_req && g) memq.push_back('{obs_addr, cyc});
      if (pop) void'(m_out.pop_front());
      if (imemRvalid_i && m_pend.size() > 0) begin
        p = m_pend.pop_front();
        if (!p.kill && !br) m_out.push_back(p.a);
      end
      if (br) begin
        m_out.delete();
        foreach (m_pend[i]) m_pend[i].kill = 1'b1;
        m_fetch = {ba[31:2], 2'b00};
      end
      if (mg) begin
        m_pend.push_back('{m_fetch, 1'b0});
        m_fetch += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk++; if (obs_req !== 1'b0) begin err++; $display("FAIL reset_req got %b exp 0", obs_req); end
      chk++; if (obs_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %b exp 0", obs_valid); end
      chk++; if (obs_inst !== 32'h0) begin err++; $display("FAIL reset_inst got %h exp 0", obs_inst); end
    end
    step(1, 0, 0, 0, 1, 1);
    chk++; if (obs_req !== 1'b1) begin err++; $display("FAIL release_req got %b exp 1", obs_req); end
    chk++; if (obs_addr !== 32'h0) begin err++; $display("FAIL release_addr got %h exp 0", obs_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] nxt = 32'h0;
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 1, 1);
      if (obs_valid) begin
        seen = 1;
        chk++; if (obs_pc !== nxt) begin err++; $display("FAIL stream_pc got %h exp %h", obs_pc, nxt); end
        chk++; if (obs_inst !== (nxt ^ K)) begin err++; $display("FAIL stream_inst got %h exp %h", obs_inst, nxt ^ K); end
        nxt += 32'd4;
      end else if (seen) begin
        chk++; err++; $display("FAIL stream_bubble got valid 0 exp 1 at cycle %0d", i);
      end
    end
    chk++; if (nxt !== 32'h28) begin err++; $display("FAIL stream_count got next pc %h exp 28", nxt); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) step(1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 1, 1);
      chk++; if (obs_req !== 1'b0) begin err++; $display("FAIL stall_req got %b exp 0", obs_req); end
      chk++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin err++; $display("FAIL stall_head got v%b %h exp v1 0", obs_valid, obs_pc); end
    end
    step(1, 0, 0, 0, 1, 1);
    chk++; if (obs_pc !== 32'h0) begin err++; $display("FAIL stall_rel0 got %h exp 0", obs_pc); end
    chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin err++; $display("FAIL stall_resume got r%b %h exp r1 8", obs_req, obs_addr); end
    step(1, 0, 0, 0, 1, 1);
    chk++; if (obs_valid !== 1'b1 || obs_pc !== 32'h4) begin err++; $display("FAIL stall_rel1 got v%b %h exp v1 4", obs_valid, obs_pc); end
  endtask

  task automatic wait_valid(input logic [31:0] pc, input string nm);
    bit got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1, 0, 0, 0, 1, 1);
      got = obs_valid;
    end
    chk++; if (!got) begin err++; $display("FAIL %s_timeout got no valid exp valid", nm); end
    chk++; if (obs_pc !== pc || obs_inst !== (pc ^ K)) begin err++; $display("FAIL %s_target got %h/%h exp %h/%h", nm, obs_pc, obs_inst, pc, pc ^ K); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 32'h100, 1, 0);
    chk++; if (obs_req !== 1'b0) begin err++; $display("FAIL redir_req got %b exp 0", obs_req); end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 1);
      chk++; if (obs_valid !== 1'b0) begin err++; $display("FAIL redir_drop got %b exp 0", obs_valid); end
    end
    chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin err++; $display("FAIL redir_addr got r%b %h exp r1 100", obs_req, obs_addr); end
    wait_valid(32'h100, "redir");
  endtask

  task automatic test_misaligned();
    do_reset();
    step(1, 0, 1, 32'h103, 1, 0);
    chk++; if (obs_req !== 1'b0) begin err++; $display("FAIL misal_req got %b exp 0", obs_req); end
    step(1, 0, 0, 0, 1, 1);
    chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin err++; $display("FAIL misal_addr got r%b %h exp r1 100", obs_req, obs_addr); end
    wait_valid(32'h100, "misal");
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin err++; $display("FAIL bp_hold got r%b %h exp r1 0", obs_req, obs_addr); end
    end
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    chk++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin err++; $display("FAIL midrst_out got r%b v%b exp r0 v0", obs_req, obs_valid); end
    step(1, 0, 0, 0, 0, 1);
    chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin err++; $display("FAIL midrst_addr got r%b %h exp r1 0", obs_req, obs_addr); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 1);
      chk++; if (obs_valid !== 1'b0) begin err++; $display("FAIL midrst_stale got %b exp 0", obs_valid); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) != 0, $urandom_range(9) < 3, $urandom_range(19) == 0,
           $urandom, $urandom_range(9) < 7, $urandom_range(9) < 6);
      chk++; if (obs_req !== exp_req) begin err++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, obs_req, exp_req); end
      if (exp_req) begin
        chk++; if (obs_addr !== exp_addr) begin err++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, obs_addr, exp_addr); end
      end
      chk++; if (obs_valid !== exp_valid) begin err++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, obs_valid, exp_valid); end
      chk++; if (obs_pc !== exp_pc) begin err++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, obs_pc, exp_pc); end
      chk++; if (obs_inst !== exp_inst) begin err++; $display("FAIL rnd_inst cyc %0d got %h exp %h", cyc, obs_inst, exp_inst); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_backpressure_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
